mem_wb_stage: RTL and testbench

MEM/WB pipeline register and write-back formatter for the 5-stage core. Captures the memory-stage result, aligns and extends load data, and selects between ALU result and load data. Drives the register file's write port (write enable, destination, data) and the WB forwarding path. Also keeps a retired-instruction counter and a sticky misaligned-load flag.

---
 rtl/mem_wb_stage.sv | 145 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formatter.
// Holds the memory-stage result for one cycle, aligns and extends load data,
// and drives the register-file write port plus the WB forwarding path.
// Also keeps a retired-instruction counter and a sticky misaligned-load flag.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             RegWrite_i,
    input  logic             MemtoReg_i,
    input  logic [4:0]       rd_i,
    input  logic [31:0]      alu_result_i,
    input  logic [31:0]      mem_rdata_i,
    input  logic [2:0]       ld_type_i,
    output logic             RegWrite_o,
    output logic [4:0]       WriteRegister_o,
    output logic [31:0]      WriteData_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Misaligned access or unrecognised load type for the given byte offset.
    function automatic logic load_bad(input logic [1:0] off, input logic [2:0] lt);
        logic bad;
        bad = 1'b1;
        case (lt)
            LD_LB, LD_LBU: bad = 1'b0;
            LD_LH, LD_LHU: bad = off[0];
            LD_LW:         bad = (off != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  lt);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] byte_x;
        logic signed [31:0] half_x;
        logic        [31:0] res;
        byte_s = signed'(word[{off, 3'b000} +: 8]);
        half_s = signed'(word[{off[1], 4'b0000} +: 16]);
        byte_x = byte_s;
        half_x = half_s;
        res    = '0;
        case (lt)
            LD_LB:   res = byte_x;
            LD_LBU:  res = {24'b0, byte_s};
            LD_LH:   res = half_x;
            LD_LHU:  res = {16'b0, half_s};
            LD_LW:   res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

    logic             vld_p1;
    logic             regwrite_p1;
    logic             memtoreg_p1;
    logic [4:0]       rd_p1;
    logic [31:0]      alu_p1;
    logic [31:0]      rdata_p1;
    logic [2:0]       ldtype_p1;
    logic             misalign_r;
    logic [CNT_W-1:0] retired_r;

    logic capture;
    logic bad_in;
    logic bad_p1;

    assign capture = !flush_i && !stall_i;
    assign bad_in  = MemtoReg_i && load_bad(alu_result_i[1:0], ld_type_i);
    assign bad_p1  = memtoreg_p1 && load_bad(alu_p1[1:0], ldtype_p1);

    // MEM -> WB pipeline register: flush beats stall, stall holds everything.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
            rd_p1       <= '0;
            alu_p1      <= '0;
            rdata_p1    <= '0;
            ldtype_p1   <= '0;
        end else if (flush_i) begin
            vld_p1      <= 1'b0;
        end else if (!stall_i) begin
            vld_p1      <= valid_i;
            regwrite_p1 <= RegWrite_i;
            memtoreg_p1 <= MemtoReg_i;
            rd_p1       <= rd_i;
            alu_p1      <= alu_result_i;
            rdata_p1    <= mem_rdata_i;
            ldtype_p1   <= ld_type_i;
        end
    end

    // Retired-instruction counter: one per valid capture, wraps naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retired_r <= '0;
        end else if (capture && valid_i) begin
            retired_r <= retired_r + CNT_W'(1);
        end
    end

    // Sticky flag for a captured register-writing load that cannot complete.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            misalign_r <= 1'b0;
        end else if (capture && valid_i && RegWrite_i && bad_in) begin
            misalign_r <= 1'b1;
        end
    end

    // Write-back port driven purely from registered state.
    always_comb begin
        RegWrite_o      = 1'b0;
        WriteRegister_o = '0;
        WriteData_o     = '0;
        if (vld_p1) begin
            RegWrite_o      = regwrite_p1 && (rd_p1 != 5'd0) && !bad_p1;
            WriteRegister_o = rd_p1;
            WriteData_o     = memtoreg_p1 ? fmt_load(rdata_p1, alu_p1[1:0], ldtype_p1)
                                          : alu_p1;
        end
    end

    assign misalign_o = misalign_r;
    assign retired_o  = retired_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage, with a second narrow-counter instance
// to observe counter wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [2:0]  ld_type;

    logic        wr_en,  wr_en4;
    logic [4:0]  wr_idx, wr_idx4;
    logic [31:0] wr_data, wr_data4;
    logic        misalign, misalign4;
    logic [31:0] retired;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
        .valid_i(valid), .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg),
        .rd_i(rd), .alu_result_i(alu), .mem_rdata_i(rdata), .ld_type_i(ld_type),
        .RegWrite_o(wr_en), .WriteRegister_o(wr_idx), .WriteData_o(wr_data),
        .misalign_o(misalign), .retired_o(retired)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
        .valid_i(valid), .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg),
        .rd_i(rd), .alu_result_i(alu), .mem_rdata_i(rdata), .ld_type_i(ld_type),
        .RegWrite_o(wr_en4), .WriteRegister_o(wr_idx4), .WriteData_o(wr_data4),
        .misalign_o(misalign4), .retired_o(retired4)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] exp_cnt;
    logic        exp_mis;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic ref_bad(input logic m2r, input logic [31:0] a, input logic [2:0] lt);
        if (!m2r) return 1'b0;
        case (lt)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return a[1:0] != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [31:0] w, input logic [2:0] lt);
        logic [31:0] sb8;
        logic [31:0] sh16;
        sb8  = w >> {a[1:0], 3'b000};
        sh16 = w >> {a[1], 4'b0000};
        case (lt)
            3'b000:  return {{24{sb8[7]}}, sb8[7:0]};
            3'b100:  return {24'h0, sb8[7:0]};
            3'b001:  return {{16{sh16[15]}}, sh16[15:0]};
            3'b101:  return {16'h0, sh16[15:0]};
            default: return w;
        endcase
    endfunction

    // Drive one cycle of stimulus, predict the WB result, then compare after the edge.
    task automatic cycle(input logic st, input logic fl, input logic v, input logic rw,
                         input logic m2r, input logic [4:0] r, input logic [31:0] a,
                         input logic [31:0] w, input logic [2:0] lt);
        exp_t e;
        exp_t got;
        logic bad;
        stall = st; flush = fl; valid = v; reg_write = rw; mem_to_reg = m2r;
        rd = r; alu = a; rdata = w; ld_type = lt;
        bad = ref_bad(m2r, a, lt);
        e = '{rw: 1'b0, idx: 5'd0, data: 32'd0, chk_data: 1'b1};
        if (fl) begin
            e = '{rw: 1'b0, idx: 5'd0, data: 32'd0, chk_data: 1'b1};
        end else if (st) begin
            e = last_exp;
        end else begin
            if (v) begin
                e.rw       = rw && (r != 5'd0) && !bad;
                e.idx      = r;
                e.data     = m2r ? ref_load(a, w, lt) : a;
                e.chk_data = !bad;
                exp_cnt    = exp_cnt + 32'd1;
                if (rw && bad) exp_mis = 1'b1;
            end
        end
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_eq("wr_en", {31'b0, wr_en}, {31'b0, got.rw});
        check_eq("wr_idx", {27'b0, wr_idx}, {27'b0, got.idx});
        if (got.chk_data) check_eq("wr_data", wr_data, got.data);
        check_eq("misalign", {31'b0, misalign}, {31'b0, exp_mis});
        check_eq("retired", retired, exp_cnt);
        check_eq("retired4", {28'b0, retired4}, {28'b0, exp_cnt[3:0]});
    endtask

    task automatic model_reset();
        exp_cnt  = 32'd0;
        exp_mis  = 1'b0;
        last_exp = '{rw: 1'b0, idx: 5'd0, data: 32'd0, chk_data: 1'b1};
    endtask

    localparam logic [31:0] RDW = 32'h80FF_7F01;

    initial begin
        rst_n = 1'b0; stall = 0; flush = 0; valid = 0; reg_write = 0; mem_to_reg = 0;
        rd = 0; alu = 0; rdata = 0; ld_type = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_en", {31'b0, wr_en}, 32'd0);
        check_eq("rst_wr_idx", {27'b0, wr_idx}, 32'd0);
        check_eq("rst_wr_data", wr_data, 32'd0);
        check_eq("rst_misalign", {31'b0, misalign}, 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        #4 rst_n = 1'b1;

        // ALU write-back
        cycle(0, 0, 1, 1, 0, 5'd5, 32'h1234_5678, 32'h0, 3'b010);
        check_eq("alu_data_const", wr_data, 32'h1234_5678);
        check_eq("alu_cnt_const", retired, 32'd1);

        // Load extension
        cycle(0, 0, 1, 1, 1, 5'd3, 32'h0000_0103, RDW, 3'b000);
        check_eq("lb_const", wr_data, 32'hFFFF_FF80);
        cycle(0, 0, 1, 1, 1, 5'd3, 32'h0000_0103, RDW, 3'b100);
        check_eq("lbu_const", wr_data, 32'h0000_0080);
        cycle(0, 0, 1, 1, 1, 5'd3, 32'h0000_0102, RDW, 3'b001);
        check_eq("lh_const", wr_data, 32'hFFFF_80FF);
        cycle(0, 0, 1, 1, 1, 5'd3, 32'h0000_0100, RDW, 3'b101);
        check_eq("lhu_const", wr_data, 32'h0000_7F01);
        cycle(0, 0, 1, 1, 1, 5'd3, 32'h0000_0104, RDW, 3'b010);
        check_eq("lw_const", wr_data, 32'h80FF_7F01);

        // rd = 0 never writes, still retires
        cycle(0, 0, 1, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 3'b010);
        check_eq("rd0_wr_en", {31'b0, wr_en}, 32'd0);

        // Stall holds outputs, then stall+flush clears
        cycle(0, 0, 1, 1, 0, 5'd9, 32'h0000_A5A5, 32'h0, 3'b010);
        for (int i = 0; i < 3; i++)
            cycle(1, 0, 1, 1, 0, 5'd12, 32'h5555_0000 + i, 32'h0, 3'b010);
        check_eq("stall_data_const", wr_data, 32'h0000_A5A5);
        cycle(1, 1, 1, 1, 0, 5'd13, 32'h7777_7777, 32'h0, 3'b010);
        check_eq("flush_wr_en_const", {31'b0, wr_en}, 32'd0);
        cycle(0, 0, 0, 1, 0, 5'd14, 32'h1111_1111, 32'h0, 3'b010);

        // Misaligned and illegal loads, then the flag stays set
        cycle(0, 0, 1, 1, 1, 5'd7, 32'h0000_1002, RDW, 3'b010);
        check_eq("mis_const", {31'b0, misalign}, 32'd1);
        cycle(0, 0, 1, 1, 1, 5'd8, 32'h0000_1001, RDW, 3'b001);
        cycle(0, 0, 1, 1, 1, 5'd8, 32'h0000_1000, RDW, 3'b011);
        cycle(0, 0, 1, 1, 0, 5'd4, 32'h0000_0042, 32'h0, 3'b010);

        // Randomised mix including stall/flush
        for (int i = 0; i < 60; i++)
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  5'($urandom), $urandom, $urandom, 3'($urandom));

        // Async reset mid-cycle while a write is active
        cycle(0, 0, 1, 1, 0, 5'd6, 32'hCAFE_0001, 32'h0, 3'b010);
        check_eq("pre_rst_wr_en", {31'b0, wr_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_wr_en", {31'b0, wr_en}, 32'd0);
        check_eq("async_wr_idx", {27'b0, wr_idx}, 32'd0);
        check_eq("async_retired", retired, 32'd0);
        check_eq("async_misalign", {31'b0, misalign}, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 16; i++)
            cycle(0, 0, 1, 1, 0, 5'd1, 32'(i), 32'h0, 3'b010);
        check_eq("wrap4_const", {28'b0, retired4}, 32'd0);
        check_eq("cnt16_const", retired, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
